basic_gate_bank: RTL and testbench

Registered bank of the seven basic two-input logic functions: AND, OR, NOT, NAND, NOR, XOR and XNOR. The functions are applied bitwise to two WIDTH-bit operands. Results are captured on a valid strobe and held, so the block can sit directly behind a bus or operand register stage. With WIDTH=1 it implements the classic single-bit gate truth table.

---
 rtl/basic_gate_bank_pkg.sv | 22 ++
 rtl/basic_gate_bank_cell.sv | 22 ++
 rtl/basic_gate_bank.sv | 98 +++++++++
 tb/tb_basic_gate_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/basic_gate_bank_pkg.sv
// Shared types and constants for the basic_gate_bank block.
// Defines the gate ordering used to index per-cell result vectors.
package basic_gate_bank_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int NUM_GATES     = 7;

  typedef enum logic [2:0] {
    GATE_AND,
    GATE_OR,
    GATE_NOT,
    GATE_NAND,
    GATE_NOR,
    GATE_XOR,
    GATE_XNOR
  } gate_e;

  function automatic int hdist_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/basic_gate_bank_cell.sv
// Combinational single-bit cell producing all seven basic gate functions.
// Output vector is indexed by gate_e.
module basic_gate_cell
  import basic_gate_bank_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] y
);

  always_comb begin
    y            = '0;
    y[GATE_AND]  = a & b;
    y[GATE_OR]   = a | b;
    y[GATE_NOT]  = ~a;
    y[GATE_NAND] = ~(a & b);
    y[GATE_NOR]  = ~(a | b);
    y[GATE_XOR]  = a ^ b;
    y[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/basic_gate_bank.sv
// Registered bitwise gate bank: one basic_gate_cell per bit, results held between strobes.
// Optional Hamming-distance output enabled by defining BASIC_GATE_BANK_HDIST_EN.
module basic_gate_bank
  import basic_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        in_valid,
  output logic [WIDTH-1:0]            and_o,
  output logic [WIDTH-1:0]            or_o,
  output logic [WIDTH-1:0]            not_o,
  output logic [WIDTH-1:0]            nand_o,
  output logic [WIDTH-1:0]            nor_o,
  output logic [WIDTH-1:0]            xor_o,
  output logic [WIDTH-1:0]            xnor_o,
`ifdef BASIC_GATE_BANK_HDIST_EN
  output logic [hdist_w(WIDTH)-1:0]   hdist_o,
`endif
  output logic                        out_valid
);

  logic [NUM_GATES-1:0][WIDTH-1:0] gate_vec;
  logic [NUM_GATES-1:0][WIDTH-1:0] res_d, res_q;
  logic                            valid_d, valid_q;

  // Each cell sees only a[i]/b[i]; results are regrouped per gate.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [NUM_GATES-1:0] cell_y;

    basic_gate_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .y (cell_y)
    );

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      assign gate_vec[g][i] = cell_y[g];
    end
  end

  always_comb begin
    res_d   = res_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d = gate_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

`ifdef BASIC_GATE_BANK_HDIST_EN
  localparam int HW = hdist_w(WIDTH);

  logic [HW-1:0] hdist_d, hdist_q;

  always_comb begin
    hdist_d = hdist_q;
    if (in_valid) begin
      hdist_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
        hdist_d = hdist_d + HW'(gate_vec[GATE_XOR][i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdist_q <= '0;
    end else begin
      hdist_q <= hdist_d;
    end
  end

  assign hdist_o = hdist_q;
`endif

  assign and_o     = res_q[GATE_AND];
  assign or_o      = res_q[GATE_OR];
  assign not_o     = res_q[GATE_NOT];
  assign nand_o    = res_q[GATE_NAND];
  assign nor_o     = res_q[GATE_NOR];
  assign xor_o     = res_q[GATE_XOR];
  assign xnor_o    = res_q[GATE_XNOR];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_basic_gate_bank.sv
// Directed self-checking bench for basic_gate_bank at WIDTH=1, 8 and 2.
// Optional hdist_o checks follow BASIC_GATE_BANK_HDIST_EN.
module tb_basic_gate_bank;

  logic clk = 1'b0;
  logic rst_n;

  logic       a1, b1, v1;
  logic       and1, or1, not1, nand1, nor1, xor1, xnor1, ov1;

  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
  logic       ov8;

  logic [1:0] a2, b2;
  logic       v2;
  logic [1:0] and2, or2, not2, nand2, nor2, xor2, xnor2;
  logic       ov2;

`ifdef BASIC_GATE_BANK_HDIST_EN
  logic       hd1;
  logic [3:0] hd8;
  logic [1:0] hd2;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  basic_gate_bank #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .and_o(and1), .or_o(or1), .not_o(not1), .nand_o(nand1),
    .nor_o(nor1), .xor_o(xor1), .xnor_o(xnor1),
`ifdef BASIC_GATE_BANK_HDIST_EN
    .hdist_o(hd1),
`endif
    .out_valid(ov1)
  );

  basic_gate_bank #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .and_o(and8), .or_o(or8), .not_o(not8), .nand_o(nand8),
    .nor_o(nor8), .xor_o(xor8), .xnor_o(xnor8),
`ifdef BASIC_GATE_BANK_HDIST_EN
    .hdist_o(hd8),
`endif
    .out_valid(ov8)
  );

  basic_gate_bank #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(v2),
    .and_o(and2), .or_o(or2), .not_o(not2), .nand_o(nand2),
    .nor_o(nor2), .xor_o(xor2), .xnor_o(xnor2),
`ifdef BASIC_GATE_BANK_HDIST_EN
    .hdist_o(hd2),
`endif
    .out_valid(ov2)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      total_cnt++;
      if ({and1, or1, not1, nand1, nor1, xor1, xnor1, ov1} !== 8'b0) begin
        $display("[TB] FAIL reset_w1 cycle %0d: got %b expected 00000000", c,
                 {and1, or1, not1, nand1, nor1, xor1, xnor1, ov1});
      end else pass_cnt++;
`ifdef BASIC_GATE_BANK_HDIST_EN
      total_cnt++;
      if (hd1 !== 1'b0) $display("[TB] FAIL reset_hdist_w1: got %b expected 0", hd1);
      else pass_cnt++;
`endif
    end
    @(negedge clk);
    v1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab_tab [4];
    logic [6:0] exp_tab [4];
    ab_tab  = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_tab = '{7'b0011101, 7'b0111010, 7'b0101010, 7'b1100001};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      {a1, b1} = ab_tab[k];
      v1 = 1'b1;
      step();
      total_cnt++;
      if ({and1, or1, not1, nand1, nor1, xor1, xnor1} !== exp_tab[k] || ov1 !== 1'b1) begin
        $display("[TB] FAIL truth_ab%b: got %b valid %b expected %b valid 1", ab_tab[k],
                 {and1, or1, not1, nand1, nor1, xor1, xnor1}, ov1, exp_tab[k]);
      end else pass_cnt++;
      @(negedge clk);
      v1 = 1'b0;
      step();
      total_cnt++;
      if (ov1 !== 1'b0) $display("[TB] FAIL truth_pulse_ab%b: got valid %b expected 0", ab_tab[k], ov1);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    step();
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      total_cnt++;
      if ({and1, or1, not1, nand1, nor1, xor1, xnor1} !== 7'b1100001 || ov1 !== 1'b0) begin
        $display("[TB] FAIL hold cycle %0d: got %b valid %b expected 1100001 valid 0", c,
                 {and1, or1, not1, nand1, nor1, xor1, xnor1}, ov1);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst_n = 1'b0;
    a8 = 8'hFF; b8 = 8'h00; v8 = 1'b1;
    step();
    total_cnt++;
    if ({and8, or8, not8, nand8, nor8, xor8, xnor8} !== 56'h0 || ov8 !== 1'b0) begin
      $display("[TB] FAIL rst_prio: got %h valid %b expected all 0 valid 0",
               {and8, or8, not8, nand8, nor8, xor8, xnor8}, ov8);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0;
    step();
    total_cnt++;
    if ({and8, or8, not8, nand8, nor8, xor8, xnor8} !== 56'h0 || ov8 !== 1'b0) begin
      $display("[TB] FAIL rst_release_idle: got %h valid %b expected all 0 valid 0",
               {and8, or8, not8, nand8, nor8, xor8, xnor8}, ov8);
    end else pass_cnt++;
    @(negedge clk);
    v8 = 1'b1;
    step();
    total_cnt++;
    if ({and8, or8, not8, nand8, nor8, xor8, xnor8} !== 56'h00_FF_00_FF_00_FF_00 || ov8 !== 1'b1) begin
      $display("[TB] FAIL rst_first_capture: got %h valid %b expected 00ff00ff00ff00 valid 1",
               {and8, or8, not8, nand8, nor8, xor8, xnor8}, ov8);
    end else pass_cnt++;
`ifdef BASIC_GATE_BANK_HDIST_EN
    total_cnt++;
    if (hd8 !== 4'd8) $display("[TB] FAIL rst_first_hdist: got %0d expected 8", hd8);
    else pass_cnt++;
`endif
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_wide();
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    step();
    total_cnt++;
    if ({and8, or8, not8, nand8, nor8, xor8, xnor8} !== 56'hC0_FC_0F_3F_03_3C_C3 || ov8 !== 1'b1) begin
      $display("[TB] FAIL wide: got %h valid %b expected c0fc0f3f033cc3 valid 1",
               {and8, or8, not8, nand8, nor8, xor8, xnor8}, ov8);
    end else pass_cnt++;
`ifdef BASIC_GATE_BANK_HDIST_EN
    total_cnt++;
    if (hd8 !== 4'd4) $display("[TB] FAIL wide_hdist: got %0d expected 4", hd8);
    else pass_cnt++;
`endif
    @(negedge clk);
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_xor [4];
    exp_xor = '{2'd1, 2'd0, 2'd3, 2'd2};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a2 = 2'(k); b2 = 2'b01; v2 = 1'b1;
      step();
      total_cnt++;
      if (xor2 !== exp_xor[k] || ov2 !== 1'b1) begin
        $display("[TB] FAIL b2b step %0d: got xor %0d valid %b expected xor %0d valid 1",
                 k, xor2, ov2, exp_xor[k]);
      end else pass_cnt++;
    end
    @(negedge clk);
    v2 = 1'b0;
    step();
    total_cnt++;
    if (ov2 !== 1'b0 || xor2 !== 2'd2) begin
      $display("[TB] FAIL b2b_end: got xor %0d valid %b expected xor 2 valid 0", xor2, ov2);
    end else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; v8 = 1'b0;
    a2 = 2'h0; b2 = 2'h0; v2 = 1'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_reset_priority();
    test_wide();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
